// File: rtl/uid_auth_table.sv
// UID authorisation table: CHECK/ADD/DEL/CLEAR served by a one-slot-per-clock scan with fixed latency.
// Define UID_AUTH_DEFAULT_UID_EN to preload DEFAULT_UID into slot 0 at reset and on CLEAR.
module uid_auth_table #(
    parameter int               UID_W       = 32,
    parameter int               DEPTH       = 8,
    parameter logic [UID_W-1:0] DEFAULT_UID = 32'hDEAD_BEEF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [1:0]                   cmd_op_i,
    input  logic [UID_W-1:0]             cmd_uid_i,
    output logic                         rsp_valid_o,
    output logic                         rsp_allowed_o,
    output logic                         rsp_added_ok_o,
    output logic                         rsp_duplicate_o,
    output logic                         rsp_full_o,
    output logic                         rsp_removed_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_CHECK = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_DEL   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`ifdef UID_AUTH_DEFAULT_UID_EN
    localparam logic [DEPTH-1:0] EMPTY_VALID = DEPTH'(1);
    localparam logic [CNT_W-1:0] EMPTY_CNT   = CNT_W'(1);
`else
    localparam logic [DEPTH-1:0] EMPTY_VALID = '0;
    localparam logic [CNT_W-1:0] EMPTY_CNT   = '0;
`endif

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic [UID_W-1:0] uid_q, uid_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             free_found_q, free_found_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [UID_W-1:0] tbl_q [DEPTH];
    logic [UID_W-1:0] tbl_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       rsp_q, rsp_d;   // {allowed, added_ok, duplicate, full, removed}
    logic             rsp_valid_q, rsp_valid_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        op_d         = op_q;
        uid_d        = uid_q;
        hit_d        = hit_q;
        hit_idx_d    = hit_idx_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        valid_d      = valid_q;
        tbl_d        = tbl_q;
        count_d      = count_q;
        rsp_d        = '0;
        rsp_valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d         = cmd_op_i;
                    uid_d        = cmd_uid_i;
                    idx_d        = '0;
                    hit_d        = 1'b0;
                    hit_idx_d    = '0;
                    free_found_d = 1'b0;
                    free_idx_d   = '0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (valid_q[idx_q] && (tbl_q[idx_q] == uid_q)) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (!valid_q[idx_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (idx_q == LAST_IDX) state_d = S_RESP;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
                case (op_q)
                    OP_CHECK: rsp_d[4] = hit_q;
                    OP_ADD: begin
                        if (hit_q) begin
                            rsp_d[2] = 1'b1;
                        end else if (!free_found_q) begin
                            rsp_d[1] = 1'b1;
                        end else begin
                            valid_d[free_idx_q] = 1'b1;
                            tbl_d[free_idx_q]   = uid_q;
                            count_d             = count_q + CNT_W'(1);
                            rsp_d[3]            = 1'b1;
                        end
                    end
                    OP_DEL: begin
                        if (hit_q) begin
                            valid_d[hit_idx_q] = 1'b0;
                            count_d            = count_q - CNT_W'(1);
                            rsp_d[0]           = 1'b1;
                        end
                    end
                    default: begin
                        valid_d  = EMPTY_VALID;
                        count_d  = EMPTY_CNT;
`ifdef UID_AUTH_DEFAULT_UID_EN
                        tbl_d[0] = DEFAULT_UID;
`endif
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            op_q         <= OP_CHECK;
            uid_q        <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            valid_q      <= EMPTY_VALID;
            count_q      <= EMPTY_CNT;
            rsp_q        <= '0;
            rsp_valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= (i == 0) ? DEFAULT_UID : '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            uid_q        <= uid_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            rsp_q        <= rsp_d;
            rsp_valid_q  <= rsp_valid_d;
            tbl_q        <= tbl_d;
        end
    end

    assign cmd_ready_o     = (state_q == S_IDLE);
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_allowed_o   = rsp_q[4];
    assign rsp_added_ok_o  = rsp_q[3];
    assign rsp_duplicate_o = rsp_q[2];
    assign rsp_full_o      = rsp_q[1];
    assign rsp_removed_o   = rsp_q[0];
    assign count_o         = count_q;
endmodule
